exc_ctrl: RTL

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_pkg.sv | 26 ++
 rtl/exc_ctrl_if.sv | 34 +++
 rtl/exc_prio_enc.sv | 32 +++
 rtl/exc_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer: cause codes, FSM encoding,
// the decoded-request record and the default handler vector / nesting limit.
package exc_pkg;

  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0040_0004;
  localparam int          MAX_DEPTH_DEF    = 6;

  localparam logic [4:0] CAUSE_NONE    = 5'b00000;
  localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
  localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRAP,
    ST_REDIRECT,
    ST_RETURN
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       is_eret;
    logic [4:0] cause;
  } exc_req_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// Pipeline-facing bundle of the exception controller: decoded instruction
// flags and PC in, CP0 / PC-register control out.
interface exc_ctrl_if;
  logic        exc_ena;
  logic        inst_syscall;
  logic        inst_break;
  logic        inst_teq;
  logic        teq_equal;
  logic        inst_eret;
  logic [31:0] pc_in;

  logic [4:0]  cause;
  logic [31:0] exc_pc;
  logic        cp0_eret;
  logic        pc_redirect;
  logic        pc_src_epc;
  logic        stall;
  logic [2:0]  depth;
  logic [1:0]  err;
  // Vector the PC register loads when pc_redirect is high and pc_src_epc is low.
  logic [31:0] handler_addr;

  modport master (
    output exc_ena, inst_syscall, inst_break, inst_teq, teq_equal, inst_eret, pc_in,
    input  cause, exc_pc, cp0_eret, pc_redirect, pc_src_epc, stall, depth, err,
           handler_addr
  );

  modport slave (
    input  exc_ena, inst_syscall, inst_break, inst_teq, teq_equal, inst_eret, pc_in,
    output cause, exc_pc, cp0_eret, pc_redirect, pc_src_epc, stall, depth, err,
           handler_addr
  );
endinterface

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: SYSCALL > BREAK > TEQ (when operands equal) > ERET.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic     syscall,
  input  logic     brk,
  input  logic     teq,
  input  logic     teq_equal,
  input  logic     eret,
  output exc_req_t req
);

  always_comb begin
    // NOTE: default every output first so no path through the if-chain leaves
    // a signal unassigned, which would otherwise infer a latch.
    req = '0;
    if (syscall) begin
      req.valid = 1'b1;
      req.cause = CAUSE_SYSCALL;
    end else if (brk) begin
      req.valid = 1'b1;
      req.cause = CAUSE_BREAK;
    end else if (teq && teq_equal) begin
      req.valid = 1'b1;
      req.cause = CAUSE_TEQ;
    end else if (eret) begin
      req.valid   = 1'b1;
      req.is_eret = 1'b1;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer: accepts one event per IDLE sample, tracks nesting
// depth, and steps TRAP -> REDIRECT or RETURN to steer the PC and CP0.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
  parameter int          MAX_DEPTH    = MAX_DEPTH_DEF
) (
  input  logic        exc_clk,
  input  logic        exc_rst_n,
  exc_ctrl_if.slave   bus
);

  localparam logic [2:0] DEPTH_MAX = 3'(MAX_DEPTH);

  state_t      state_q, state_d;
  logic [2:0]  depth_q, depth_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] exc_pc_q, exc_pc_d;
  logic [4:0]  trap_cause_q, trap_cause_d;
  exc_req_t    req;

  exc_prio_enc u_prio (
    .syscall   (bus.inst_syscall),
    .brk       (bus.inst_break),
    .teq       (bus.inst_teq),
    .teq_equal (bus.teq_equal),
    .eret      (bus.inst_eret),
    .req       (req)
  );

  // NOTE: every register here is reset because the outputs are decoded from
  // them; a mid-sequence reset must drop stall and strobes immediately.
  always_ff @(posedge exc_clk or negedge exc_rst_n) begin
    if (!exc_rst_n) begin
      state_q      <= ST_IDLE;
      depth_q      <= '0;
      err_q        <= '0;
      exc_pc_q     <= '0;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      // NOTE: non-blocking so all registers update from the same pre-edge values.
      state_q      <= state_d;
      depth_q      <= depth_d;
      err_q        <= err_d;
      exc_pc_q     <= exc_pc_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    depth_d         = depth_q;
    err_d           = err_q;
    exc_pc_d        = exc_pc_q;
    trap_cause_d    = trap_cause_q;
    bus.cause       = CAUSE_NONE;
    bus.cp0_eret    = 1'b0;
    bus.pc_redirect = 1'b0;
    bus.pc_src_epc  = 1'b0;
    bus.stall       = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        bus.stall = 1'b0;
        if (bus.exc_ena && req.valid) begin
          if (!req.is_eret) begin
            state_d      = ST_TRAP;
            trap_cause_d = req.cause;
            exc_pc_d     = bus.pc_in;
            // Overflowing traps are still taken; only the flag records them.
            if (depth_q == DEPTH_MAX) err_d[0] = 1'b1;
            else                      depth_d  = depth_q + 3'd1;
          end else if (depth_q != 3'd0) begin
            state_d = ST_RETURN;
            depth_d = depth_q - 3'd1;
          end else begin
            err_d[1] = 1'b1;
          end
        end
      end
      ST_TRAP: begin
        bus.cause = trap_cause_q;
        if (bus.exc_ena) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        bus.pc_redirect = 1'b1;
        if (bus.exc_ena) state_d = ST_IDLE;
      end
      ST_RETURN: begin
        bus.cp0_eret    = 1'b1;
        bus.pc_redirect = 1'b1;
        bus.pc_src_epc  = 1'b1;
        if (bus.exc_ena) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.exc_pc       = exc_pc_q;
  assign bus.depth        = depth_q;
  assign bus.err          = err_q;
  assign bus.handler_addr = HANDLER_ADDR;

endmodule
